// File: rtl/gate_duty_if.sv
// Gate-line bundle and duty-result handshake shared by the gate duty decoder and its driver.
interface gate_duty_if #(
  parameter int DUTY_W = 10
);
  logic              sync;
  logic              g1_a;
  logic              g1_b;
  logic              g1_c;
  logic              g2_a;
  logic              g2_b;
  logic              g2_c;
  logic [DUTY_W-1:0] duty_a;
  logic [DUTY_W-1:0] duty_b;
  logic [DUTY_W-1:0] duty_c;
  logic              duty_valid;
  logic              duty_ready;
  logic              overrun;
  logic [2:0]        fault;

  modport master (
    output sync, g1_a, g1_b, g1_c, g2_a, g2_b, g2_c, duty_ready,
    input  duty_a, duty_b, duty_c, duty_valid, overrun, fault
  );

  modport slave (
    input  sync, g1_a, g1_b, g1_c, g2_a, g2_b, g2_c, duty_ready,
    output duty_a, duty_b, duty_c, duty_valid, overrun, fault
  );
endinterface

// File: rtl/gate_duty_decoder.sv
// Recovers per-carrier-period high time of each upper gate; optional shoot-through
// detection is built only when GATE_DUTY_FAULT_EN is defined.
module gate_duty_decoder #(
  parameter int PERIOD = 960,
  parameter int DUTY_W = 10
) (
  input logic        clk,
  input logic        reset,
  gate_duty_if.slave bus
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]             r_cnt;
  logic [2:0][DUTY_W-1:0]       r_acc;
  logic [2:0][DUTY_W-1:0]       r_duty;
  logic                         r_valid;
  logic                         r_overrun;

  logic [2:0]                   w_g1;
  logic [2:0][DUTY_W:0]         w_sum;
  logic [2:0][DUTY_W-1:0]       w_final;
  logic                         w_eow;
  logic                         w_xfer;
  logic                         w_free;

  assign w_g1   = {bus.g1_c, bus.g1_b, bus.g1_a};
  assign w_eow  = (r_cnt == CNT_LAST) | bus.sync;
  assign w_xfer = r_valid & bus.duty_ready;
  assign w_free = ~r_valid | bus.duty_ready;

  // Final count includes the current cycle's gate level; overflow clamps at all-ones.
  always_comb begin
    w_sum   = '0;
    w_final = '0;
    for (int i = 0; i < 3; i++) begin
      w_sum[i]   = {1'b0, r_acc[i]} + {{DUTY_W{1'b0}}, w_g1[i]};
      w_final[i] = w_sum[i][DUTY_W] ? {DUTY_W{1'b1}} : w_sum[i][DUTY_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_eow) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_final;
    end
  end

  // A window closing while the slot is held and not being taken is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_eow) begin
      if (w_free) begin
        r_duty  <= w_final;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.duty_a     = r_duty[0];
  assign bus.duty_b     = r_duty[1];
  assign bus.duty_c     = r_duty[2];
  assign bus.duty_valid = r_valid;
  assign bus.overrun    = r_overrun;

`ifdef GATE_DUTY_FAULT_EN
  logic [2:0] w_g2;
  logic [2:0] r_fault;

  assign w_g2 = {bus.g2_c, bus.g2_b, bus.g2_a};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault <= '0;
    end else begin
      r_fault <= r_fault | (w_g1 & w_g2);
    end
  end

  assign bus.fault = r_fault;
`else
  assign bus.fault = 3'b000;
`endif

endmodule

// File: tb/tb_gate_duty_decoder.sv
// Randomised scoreboard bench for gate_duty_decoder, with a second narrow-result
// instance exercising saturation.
module tb_gate_duty_decoder;

  localparam int PERIOD = 16;
  localparam int DUTY_W = 5;
  localparam int SAT_W  = 3;
  localparam int MAX_W  = (1 << DUTY_W) - 1;
  localparam int MAX_S  = (1 << SAT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  gate_duty_if #(.DUTY_W(DUTY_W)) bus ();
  gate_duty_if #(.DUTY_W(SAT_W))  satBus ();

  gate_duty_decoder #(.PERIOD(PERIOD), .DUTY_W(DUTY_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  gate_duty_decoder #(.PERIOD(PERIOD), .DUTY_W(SAT_W)) dutSat (
    .clk  (clk),
    .reset(reset),
    .bus  (satBus.slave)
  );

  always #5 clk = ~clk;

  int                       modelCnt;
  bit                       modelValid;
  bit                       overrunExp;
  logic [2:0]               faultExp;
  int                       winCount[3];
  logic [3*DUTY_W-1:0]      expQ[$];
  logic [3*SAT_W-1:0]       satQ[$];
  int                       checkCount = 0;
  int                       passCount  = 0;
  bit                       started    = 1'b0;
  logic [3*DUTY_W-1:0]      expMain;
  logic [3*SAT_W-1:0]       expSat;

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit s, input bit rdy, input bit rst,
                               input logic [2:0] g1, input logic [2:0] g2);
    reset             = rst;
    bus.sync          = s;
    satBus.sync       = s;
    {bus.g1_c, bus.g1_b, bus.g1_a}       = g1;
    {satBus.g1_c, satBus.g1_b, satBus.g1_a} = g1;
    {bus.g2_c, bus.g2_b, bus.g2_a}       = g2;
    {satBus.g2_c, satBus.g2_b, satBus.g2_a} = g2;
    bus.duty_ready    = rdy;
    satBus.duty_ready = 1'b1;
  endtask

  // Reference: counts high cycles per window and decides what the consumer should see.
  task automatic modelStep();
    logic [2:0] g1;
    bit         eow;
    int         fin[3];
    g1 = {bus.g1_c, bus.g1_b, bus.g1_a};
    if (reset) begin
      modelCnt   = 0;
      modelValid = 1'b0;
      overrunExp = 1'b0;
      faultExp   = 3'b000;
      foreach (winCount[i]) winCount[i] = 0;
      expQ.delete();
      satQ.delete();
      return;
    end
`ifdef GATE_DUTY_FAULT_EN
    faultExp = faultExp | (g1 & {bus.g2_c, bus.g2_b, bus.g2_a});
`endif
    eow = (modelCnt == PERIOD - 1) || bus.sync;
    for (int i = 0; i < 3; i++) fin[i] = winCount[i] + int'(g1[i]);
    if (eow) begin
      if (!modelValid || bus.duty_ready) begin
        expQ.push_back({DUTY_W'(minInt(fin[2], MAX_W)), DUTY_W'(minInt(fin[1], MAX_W)),
                        DUTY_W'(minInt(fin[0], MAX_W))});
        modelValid = 1'b1;
      end else begin
        overrunExp = 1'b1;
      end
      satQ.push_back({SAT_W'(minInt(fin[2], MAX_S)), SAT_W'(minInt(fin[1], MAX_S)),
                      SAT_W'(minInt(fin[0], MAX_S))});
      foreach (winCount[i]) winCount[i] = 0;
      modelCnt = 0;
    end else begin
      for (int i = 0; i < 3; i++) winCount[i] = fin[i];
      if (modelValid && bus.duty_ready) modelValid = 1'b0;
      modelCnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
    started = 1'b1;
  endtask

  // Monitor: flags and handshake every cycle, result payload on each transfer.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("duty_valid", int'(bus.duty_valid), int'(modelValid));
      checkOutput("overrun", int'(bus.overrun), int'(overrunExp));
      checkOutput("fault", int'(bus.fault), int'(faultExp));
      if (bus.duty_valid && bus.duty_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("xfer_expected", 0, 1);
        end else begin
          expMain = expQ.pop_front();
          checkOutput("duty_a", int'(bus.duty_a), int'(expMain[DUTY_W-1:0]));
          checkOutput("duty_b", int'(bus.duty_b), int'(expMain[2*DUTY_W-1:DUTY_W]));
          checkOutput("duty_c", int'(bus.duty_c), int'(expMain[3*DUTY_W-1:2*DUTY_W]));
        end
      end
      if (satBus.duty_valid) begin
        if (satQ.size() == 0) begin
          checkOutput("sat_xfer_expected", 0, 1);
        end else begin
          expSat = satQ.pop_front();
          checkOutput("sat_duty_a", int'(satBus.duty_a), int'(expSat[SAT_W-1:0]));
          checkOutput("sat_duty_b", int'(satBus.duty_b), int'(expSat[2*SAT_W-1:SAT_W]));
          checkOutput("sat_duty_c", int'(satBus.duty_c), int'(expSat[3*SAT_W-1:2*SAT_W]));
        end
      end
    end
  end

  initial begin
    logic [2:0] g1;
    logic [2:0] g2;
    modelCnt   = 0;
    modelValid = 1'b0;
    overrunExp = 1'b0;
    faultExp   = 3'b000;
    foreach (winCount[i]) winCount[i] = 0;

    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 3'b000);
    tick();
    tick();

    // Fixed duties: a=6, b=0, c=full window.
    for (int k = 0; k < 3 * PERIOD; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, {1'b1, 1'b0, (modelCnt < 6)}, 3'b000);
      tick();
    end

    // Consumer stalls: first window result held, later windows dropped.
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < PERIOD; k++) begin
        applyStimulus(1'b0, (w == 0 && k == 0), 1'b0,
                      {2'b00, (modelCnt < ((w == 0) ? 4 : 9))}, 3'b000);
        tick();
      end
    end
    for (int k = 0; k < PERIOD; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, {2'b00, (modelCnt < 11)}, 3'b000);
      tick();
    end

    // Early sync truncates a fully-high window.
    for (int k = 0; k < PERIOD + 8; k++) begin
      applyStimulus((k == 7), 1'b1, 1'b0, 3'b111, 3'b000);
      tick();
    end

    // Back-to-back syncs, each a one-cycle window.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 3'($urandom), 3'b000);
      tick();
    end

    // Reset in the middle of a window.
    for (int k = 0; k < 2 * PERIOD && modelCnt != 10; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b001, 3'b000);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b001, 3'b000);
    tick();
    for (int k = 0; k < PERIOD + 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, {2'b00, (modelCnt < 5)}, 3'b000);
      tick();
    end

    // Single-cycle shoot-through on leg B.
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 3'b010);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
      tick();
    end

    // Random traffic.
    for (int k = 0; k < 700; k++) begin
      g1 = 3'($urandom);
`ifdef GATE_DUTY_FAULT_EN
      g2 = ($urandom_range(0, 59) == 0) ? 3'($urandom) : 3'b000;
`else
      g2 = 3'($urandom);
`endif
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 349) == 0), g1, g2);
      tick();
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
    for (int k = 0; k < PERIOD + 4; k++) tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
